// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

    localparam int LOG2N_DEF    = 10;
    localparam int PIPE_LAT_DEF = 3;
    localparam int STAGE_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_e;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Maps (stage, butterfly index) to the two in-place leg addresses and
// the twiddle ROM index of a radix-2 DIT butterfly.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [STAGE_W-1:0] stage_i,
    input  logic [LOG2N-2:0]   bfly_i,
    output logic [LOG2N-1:0]   addr0_o,
    output logic [LOG2N-1:0]   addr1_o,
    output logic [LOG2N-2:0]   tw_o
);

    localparam logic [STAGE_W-1:0] TW_TOP = STAGE_W'(LOG2N - 1);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k_ext   = {1'b0, bfly_i};
        half    = LOG2N'(1) << stage_i;
        pos     = k_ext & (half - LOG2N'(1));
        grp     = k_ext >> stage_i;
        addr0_o = (grp << (stage_i + STAGE_W'(1))) | pos;
        // Bit s of addr0 is always clear, so the add never carries out.
        addr1_o = addr0_o + half;
        tw_full = pos << (TW_TOP - stage_i);
        tw_o    = tw_full[LOG2N-2:0];
    end

endmodule

// File: rtl/fft_bf_sched.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly read per cycle
// and replays the same addresses as writes PIPE_LAT cycles later.
module fft_bf_sched
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               rd_en_o,
    output logic [LOG2N-1:0]   rd_addr0_o,
    output logic [LOG2N-1:0]   rd_addr1_o,
    output logic [LOG2N-2:0]   tw_addr_o,
    output logic               wr_en_o,
    output logic [LOG2N-1:0]   wr_addr0_o,
    output logic [LOG2N-1:0]   wr_addr1_o
);

    localparam int KW  = LOG2N - 1;
    localparam int DW  = cnt_w(PIPE_LAT);
    localparam int DLW = 1 + 2 * LOG2N;

    localparam logic [KW-1:0]      K_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [DW-1:0]      D_LAST = DW'(PIPE_LAT - 1);

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [DW-1:0]      dr_q, dr_d;

    logic               rd_en_d;
    logic [LOG2N-1:0]   a0_d, a1_d;
    logic [KW-1:0]      tw_d;

    logic               busy_q, done_q, rd_en_q;
    logic [STAGE_W-1:0] stage_q;
    logic [LOG2N-1:0]   rd_addr0_q, rd_addr1_q;
    logic [KW-1:0]      tw_addr_q;
    logic [DLW-1:0]     dl_q [PIPE_LAT];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        dr_d    = dr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                    dr_d    = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                // Hold issue until the stage's last write has landed.
                if (dr_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + STAGE_W'(1);
                    end
                end else begin
                    dr_d = dr_q + DW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_en_d = (state_d == ST_RUN);
    end

    fft_bf_addr_gen #(
        .LOG2N(LOG2N)
    ) u_addr_gen (
        .stage_i (s_d),
        .bfly_i  (k_d),
        .addr0_o (a0_d),
        .addr1_o (a1_d),
        .tw_o    (tw_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            s_q        <= '0;
            dr_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stage_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            tw_addr_q  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            s_q        <= s_d;
            dr_q       <= dr_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
            stage_q    <= (state_d == ST_IDLE) ? '0 : s_d;
            rd_en_q    <= rd_en_d;
            rd_addr0_q <= rd_en_d ? a0_d : '0;
            rd_addr1_q <= rd_en_d ? a1_d : '0;
            tw_addr_q  <= rd_en_d ? tw_d : '0;
            dl_q[0]    <= {rd_en_q, rd_addr0_q, rd_addr1_q};
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign stage_o    = stage_q;
    assign rd_en_o    = rd_en_q;
    assign rd_addr0_o = rd_addr0_q;
    assign rd_addr1_o = rd_addr1_q;
    assign tw_addr_o  = tw_addr_q;
    assign {wr_en_o, wr_addr0_o, wr_addr1_o} = dl_q[PIPE_LAT-1];

endmodule
